// File: rtl/proc_mem_arbiter_pkg.sv
// Shared types and constants for the imem/dmem memory-port arbiter:
// 4B memory message structs, requester IDs and arbitration modes.
package proc_mem_arbiter_pkg;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    typedef logic proc_mem_arb_id_t;

    localparam proc_mem_arb_id_t PROC_MEM_ARB_IMEM = 1'b0;
    localparam proc_mem_arb_id_t PROC_MEM_ARB_DMEM = 1'b1;

    localparam int unsigned PROC_MEM_ARB_MODE_RR    = 0;
    localparam int unsigned PROC_MEM_ARB_MODE_FIXED = 1;

    // A depth-1 queue still needs a one-bit pointer.
    function automatic int unsigned idq_ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/proc_mem_arbiter_idq.sv
// In-order FIFO of requester IDs, one entry per request in flight to memory.
// A push into a full queue or a pop from an empty one is ignored.
module proc_mem_arbiter_idq
    import proc_mem_arbiter_pkg::*;
#(
    parameter int unsigned p_depth = 4
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             push_val,
    input  proc_mem_arb_id_t push_id,
    input  logic             pop_val,
    output logic             empty,
    output logic             full,
    output proc_mem_arb_id_t head,
    output logic [4:0]       count
);

    localparam int unsigned      PTR_W  = idq_ptr_width(p_depth);
    localparam logic [PTR_W-1:0] LAST   = PTR_W'(p_depth - 1);
    localparam logic [4:0]       DEPTH5 = 5'(p_depth);

    proc_mem_arb_id_t entries_q [p_depth];
    proc_mem_arb_id_t entries_d [p_depth];
    logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
    logic [PTR_W-1:0] tail_ptr_q, tail_ptr_d;
    logic [4:0]       count_q, count_d;
    logic             do_push, do_pop;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == 5'd0);
    assign full    = (count_q == DEPTH5);
    assign head    = entries_q[head_ptr_q];
    assign count   = count_q;
    assign do_push = push_val && !full;
    assign do_pop  = pop_val && !empty;

    always_comb begin
        entries_d  = entries_q;
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        count_d    = count_q;
        if (do_push) begin
            entries_d[tail_ptr_q] = push_id;
            tail_ptr_d            = next_ptr(tail_ptr_q);
        end
        if (do_pop) begin
            head_ptr_d = next_ptr(head_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            count_q    <= '0;
        end else begin
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
            count_q    <= count_d;
        end
        entries_q <= entries_d;
    end

endmodule

// File: rtl/proc_mem_arbiter.sv
// Shares one 4B memory port between imem and dmem; requests pass through
// combinationally and an ID queue steers in-order responses back.
module proc_mem_arbiter
    import proc_mem_arbiter_pkg::*;
#(
    parameter int unsigned p_max_outstanding = 4,
    parameter int unsigned p_arb_mode        = 0
)(
    input  logic         clk,
    input  logic         reset,

    input  mem_req_4B_t  imem_req_msg,
    input  logic         imem_req_val,
    output logic         imem_req_rdy,

    input  mem_req_4B_t  dmem_req_msg,
    input  logic         dmem_req_val,
    output logic         dmem_req_rdy,

    output mem_req_4B_t  mem_req_msg,
    output logic         mem_req_val,
    input  logic         mem_req_rdy,

    input  mem_resp_4B_t mem_resp_msg,
    input  logic         mem_resp_val,
    output logic         mem_resp_rdy,

    output mem_resp_4B_t imem_resp_msg,
    output logic         imem_resp_val,
    input  logic         imem_resp_rdy,

    output mem_resp_4B_t dmem_resp_msg,
    output logic         dmem_resp_val,
    input  logic         dmem_resp_rdy,

    output logic [4:0]   num_outstanding
);

    proc_mem_arb_id_t rr_pref_q, rr_pref_d;
    proc_mem_arb_id_t id_head;
    proc_mem_arb_id_t push_id;
    logic             id_empty, id_full;
    logic             grant_dmem, grant_imem;
    logic             can_issue, req_fire, resp_fire, head_rdy;

    // Grant considers only valid requesters and never looks at the *_req_rdy outputs.
    always_comb begin
        if (p_arb_mode == PROC_MEM_ARB_MODE_FIXED) begin
            grant_dmem = dmem_req_val;
        end else if (imem_req_val && dmem_req_val) begin
            grant_dmem = (rr_pref_q == PROC_MEM_ARB_DMEM);
        end else begin
            grant_dmem = dmem_req_val;
        end
    end

    assign grant_imem   = imem_req_val && !grant_dmem;
    assign can_issue    = mem_req_rdy && !id_full;
    assign mem_req_val  = reset && (imem_req_val || dmem_req_val) && !id_full;
    assign mem_req_msg  = grant_dmem ? dmem_req_msg : imem_req_msg;
    assign imem_req_rdy = reset && grant_imem && can_issue;
    assign dmem_req_rdy = reset && grant_dmem && can_issue;
    assign req_fire     = mem_req_val && mem_req_rdy;
    assign push_id      = grant_dmem ? PROC_MEM_ARB_DMEM : PROC_MEM_ARB_IMEM;

    always_comb begin
        rr_pref_d = rr_pref_q;
        if (req_fire) begin
            rr_pref_d = grant_dmem ? PROC_MEM_ARB_IMEM : PROC_MEM_ARB_DMEM;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_pref_q <= PROC_MEM_ARB_IMEM;
        end else begin
            rr_pref_q <= rr_pref_d;
        end
    end

    // Responses return in issue order, so the queue head names the owner.
    assign imem_resp_msg = mem_resp_msg;
    assign dmem_resp_msg = mem_resp_msg;
    assign imem_resp_val = reset && mem_resp_val && !id_empty && (id_head == PROC_MEM_ARB_IMEM);
    assign dmem_resp_val = reset && mem_resp_val && !id_empty && (id_head == PROC_MEM_ARB_DMEM);
    assign head_rdy      = (id_head == PROC_MEM_ARB_DMEM) ? dmem_resp_rdy : imem_resp_rdy;
    assign mem_resp_rdy  = reset && !id_empty && head_rdy;
    assign resp_fire     = mem_resp_val && mem_resp_rdy;

    proc_mem_arbiter_idq #(
        .p_depth (p_max_outstanding)
    ) idq (
        .clk      (clk),
        .reset    (reset),
        .push_val (req_fire),
        .push_id  (push_id),
        .pop_val  (resp_fire),
        .empty    (id_empty),
        .full     (id_full),
        .head     (id_head),
        .count    (num_outstanding)
    );

    resp_while_empty_a: assert property (@(posedge clk) disable iff (!reset)
        mem_resp_val |-> !id_empty);

endmodule
